// File: rtl/regfile_pkg.sv
// Shared register-file constants: default requester count, address and data widths.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int NREQ = 3;   // write-back sources: ALU, load unit, mult/div
  localparam int AW   = 5;   // 32 architectural registers
  localparam int DW   = 32;

  // Register 0 is hardwired; writes to it are discarded and it is never busy.
  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr, ptr moves past the winner.
// Latency: grant is combinational from req; ptr updates on the accepting edge.
// Backpressure: none of its own; ptr only advances when the caller signals accept.
//
// Ports:
//   clk, rst  clock, asynchronous active-low reset (ptr -> 0)
//   req       request vector, one bit per requester
//   accept    the current grant was consumed this cycle
//   grant     one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the register-file write port among NREQ sources, tracks pending dests.
// Latency: grant combinational; rf write one cycle after transfer; q_busy combinational.
// Backpressure: write port always drains; a requester waits only when it loses arbitration.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/ready/addr/data  per-requester write-back handshake (slice i = requester i)
//   rf_we/waddr/wdata          registered register-file write port
//   sb_set, sb_set_addr        decode marks a destination pending
//   q_addr1/2, q_busy1/2       scoreboard query ports for rs/rt
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = regfile_pkg::NREQ,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_set_addr,
  input  logic [AW-1:0]     q_addr1,
  input  logic [AW-1:0]     q_addr2,
  output logic              q_busy1,
  output logic              q_busy2
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NREQ-1:0]  grant;
  logic             xfer;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;
  logic [NREGS-1:0] busy;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (xfer),
    .grant  (grant)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted then.
  assign req_ready = grant & {NREQ{rst}};
  assign xfer      = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Output register. A transfer to register 0 is consumed but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= xfer && (sel_addr != ZERO);
      if (xfer) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Pending scoreboard. When a new producer is issued on the same edge the
  // old one writes back, the set wins so the newer producer is still tracked.
  // Bit 0 is only ever reset, so register 0 is never busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      for (int a = 1; a < NREGS; a++) begin
        if (sb_set && (sb_set_addr == AW'(a))) begin
          busy[a] <= 1'b1;
        end else if (rf_we && (rf_waddr == AW'(a))) begin
          busy[a] <= 1'b0;
        end
      end
    end
  end

  // A write leaving this cycle reaches decode via the register-file bypass,
  // so it is masked out rather than stalling.
  assign q_busy1 = (q_addr1 != ZERO) && busy[q_addr1] && !(rf_we && (rf_waddr == q_addr1));
  assign q_busy2 = (q_addr2 != ZERO) && busy[q_addr2] && !(rf_we && (rf_waddr == q_addr2));

endmodule
